// File: rtl/mxv_engine.sv
// mxv_engine: y = A*x for a run-time N x N unsigned matrix (1..MAX_N), LANES rows per pass.
// Define MXV_SAT_EN for saturating accumulation; otherwise sums wrap modulo 2^ACC_W.
module mxv_engine #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int MAX_N  = 8,
    parameter int ACC_W  = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              mat_size,
    input  logic [MAX_N*DATA_W-1:0] vec_in,
    output logic [LANES-1:0]        ram_rd_en,
    output logic [LANES*4-1:0]      ram_row,
    output logic [LANES*4-1:0]      ram_col,
    input  logic [LANES*DATA_W-1:0] ram_data,
    output logic                    busy,
    output logic                    op_done,
    output logic                    size_err,
    output logic [MAX_N*ACC_W-1:0]  result
);

    localparam int PROD_W = 2 * DATA_W;
`ifdef MXV_SAT_EN
    localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
`else
    localparam int SUM_W = ACC_W;
`endif
    localparam logic [3:0] MAX_N_L = 4'(MAX_N);
    localparam logic [4:0] LANES_L = 5'(LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    logic [3:0]             n_r;
    logic [3:0]             col_r;
    logic [3:0]             col_d_r;
    logic [4:0]             base_r;
    logic [DATA_W-1:0]      x_r [16];
    logic [ACC_W-1:0]       acc_r [LANES];
    logic [LANES-1:0]       rd_en_r;
    logic [LANES-1:0]       rd_en_d_r;
    logic [LANES*4-1:0]     row_r;
    logic [LANES*4-1:0]     colo_r;
    logic                   busy_r;
    logic                   op_done_r;
    logic                   size_err_r;
    logic [MAX_N*ACC_W-1:0] result_r;

    logic                   size_ok_s;
    logic [4:0]             issue_base_s;
    logic [3:0]             issue_n_s;
    logic [LANES-1:0]       issue_act_s;
    logic [4:0]             issue_row_s [LANES];
    logic [4:0]             lane_row_s [LANES];
    logic [PROD_W-1:0]      prod_s [LANES];
    logic [SUM_W-1:0]       sum_s [LANES];
    logic [ACC_W-1:0]       acc_next_s [LANES];

    // Row base and lane activity for the pass about to be issued (first pass from IDLE, next from DRAIN).
    always_comb begin
        size_ok_s = (mat_size != 4'd0) && (mat_size <= MAX_N_L);
        if (state_r == IDLE) begin
            issue_base_s = 5'd0;
            issue_n_s    = mat_size;
        end else begin
            issue_base_s = base_r + LANES_L;
            issue_n_s    = n_r;
        end
        for (int l = 0; l < LANES; l++) begin
            issue_row_s[l] = issue_base_s + 5'(l);
            issue_act_s[l] = (issue_row_s[l] < {1'b0, issue_n_s});
            lane_row_s[l]  = base_r + 5'(l);
        end
    end

    // Per-lane multiply-accumulate on the data returned for the previously issued column.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod_s[l] = {{DATA_W{1'b0}}, ram_data[l*DATA_W +: DATA_W]} *
                        {{DATA_W{1'b0}}, x_r[col_d_r]};
            sum_s[l]  = SUM_W'(acc_r[l]) + SUM_W'(prod_s[l]);
`ifdef MXV_SAT_EN
            if (|sum_s[l][SUM_W-1:ACC_W]) begin
                acc_next_s[l] = {ACC_W{1'b1}};
            end else begin
                acc_next_s[l] = sum_s[l][ACC_W-1:0];
            end
`else
            acc_next_s[l] = sum_s[l];
`endif
        end
    end

    // Control FSM: read issue, accumulation, per-pass result write-back and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            n_r        <= 4'd0;
            col_r      <= 4'd0;
            col_d_r    <= 4'd0;
            base_r     <= 5'd0;
            rd_en_r    <= {LANES{1'b0}};
            rd_en_d_r  <= {LANES{1'b0}};
            row_r      <= {(LANES*4){1'b0}};
            colo_r     <= {(LANES*4){1'b0}};
            busy_r     <= 1'b0;
            op_done_r  <= 1'b0;
            size_err_r <= 1'b0;
            result_r   <= {(MAX_N*ACC_W){1'b0}};
            for (int i = 0; i < 16; i++) begin
                x_r[i] <= {DATA_W{1'b0}};
            end
            for (int l = 0; l < LANES; l++) begin
                acc_r[l] <= {ACC_W{1'b0}};
            end
        end else begin
            op_done_r  <= 1'b0;
            size_err_r <= 1'b0;
            rd_en_d_r  <= rd_en_r;
            col_d_r    <= col_r;
            case (state_r)
                IDLE: begin
                    if (start && size_ok_s) begin
                        state_r  <= RUN;
                        busy_r   <= 1'b1;
                        n_r      <= mat_size;
                        base_r   <= 5'd0;
                        col_r    <= 4'd0;
                        result_r <= {(MAX_N*ACC_W){1'b0}};
                        for (int i = 0; i < MAX_N; i++) begin
                            x_r[i] <= vec_in[i*DATA_W +: DATA_W];
                        end
                        for (int l = 0; l < LANES; l++) begin
                            acc_r[l]           <= {ACC_W{1'b0}};
                            rd_en_r[l]         <= issue_act_s[l];
                            row_r[l*4 +: 4]    <= issue_act_s[l] ? issue_row_s[l][3:0] : 4'd0;
                            colo_r[l*4 +: 4]   <= 4'd0;
                        end
                    end else if (start) begin
                        size_err_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (rd_en_d_r[l]) begin
                            acc_r[l] <= acc_next_s[l];
                        end
                    end
                    if (col_r == n_r - 4'd1) begin
                        state_r <= DRAIN;
                        rd_en_r <= {LANES{1'b0}};
                        row_r   <= {(LANES*4){1'b0}};
                        colo_r  <= {(LANES*4){1'b0}};
                    end else begin
                        col_r <= col_r + 4'd1;
                        for (int l = 0; l < LANES; l++) begin
                            colo_r[l*4 +: 4] <= rd_en_r[l] ? (col_r + 4'd1) : 4'd0;
                        end
                    end
                end
                DRAIN: begin
                    // The last read of the pass lands now, so its sum goes straight to the result slot.
                    for (int s = 0; s < MAX_N; s++) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (rd_en_d_r[l] && (lane_row_s[l] == 5'(s))) begin
                                result_r[s*ACC_W +: ACC_W] <= acc_next_s[l];
                            end
                        end
                    end
                    for (int l = 0; l < LANES; l++) begin
                        acc_r[l] <= {ACC_W{1'b0}};
                    end
                    if (issue_base_s < {1'b0, n_r}) begin
                        state_r <= RUN;
                        base_r  <= issue_base_s;
                        col_r   <= 4'd0;
                        for (int l = 0; l < LANES; l++) begin
                            rd_en_r[l]       <= issue_act_s[l];
                            row_r[l*4 +: 4]  <= issue_act_s[l] ? issue_row_s[l][3:0] : 4'd0;
                            colo_r[l*4 +: 4] <= 4'd0;
                        end
                    end else begin
                        state_r   <= DONE;
                        op_done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    rd_en_r <= {LANES{1'b0}};
                    row_r   <= {(LANES*4){1'b0}};
                    colo_r  <= {(LANES*4){1'b0}};
                end
            endcase
        end
    end

    assign ram_rd_en = rd_en_r;
    assign ram_row   = row_r;
    assign ram_col   = colo_r;
    assign busy      = busy_r;
    assign op_done   = op_done_r;
    assign size_err  = size_err_r;
    assign result    = result_r;

endmodule

// File: doc/mxv_engine.md
# mxv_engine

Parametrised matrix-vector multiply engine: the next-generation processor core of the matrix accelerator. It computes y = A·x for an N×N unsigned matrix A, with N chosen at run time (1..MAX_N). A is held in external single-port RAM banks; x is captured from a flat vector bus. LANES processing lanes each fetch one matrix element per cycle. The engine sits between the UART/RAM control path and the result serializer, and replaces the fixed 4-lane processor with real completion signalling and size checking.

## Interface
- LANES, 4, number of parallel lanes; each lane reads its own RAM bank port.
- DATA_W, 8, width of matrix and vector elements (unsigned).
- MAX_N, 8, maximum matrix dimension; must be ≤ 15.
- ACC_W, 20, accumulator/result element width; must be ≥ 2·DATA_W + clog2(MAX_N) unless overflow handling is intended.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin operation; sampled only in IDLE
- mat_size  in  4  matrix dimension N, sampled with start
- vec_in  in  MAX_N·DATA_W  vector x; element i at bits [i·DATA_W +: DATA_W]; sampled with start
- ram_rd_en  out  LANES  per-lane read strobe
- ram_row  out  LANES·4  per-lane row index (bank select)
- ram_col  out  LANES·4  per-lane column index (address)
- ram_data  in  LANES·DATA_W  per-lane read data, valid exactly 1 cycle after ram_rd_en
- busy  out  1  high from the cycle after start is accepted until op_done falls
- op_done  out  1  single-cycle completion pulse
- size_err  out  1  single-cycle pulse on a rejected start
- result  out  MAX_N·ACC_W  y; element r at bits [r·ACC_W +: ACC_W]

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with 1 ≤ mat_size ≤ MAX_N: capture N and vec_in, clear result and accumulators, set pass p=0 and column c=0, go to RUN.
  - start with an invalid size: pulse size_err and stay in IDLE. result is unchanged.
- Passes: P = ceil(N/LANES). In pass p, lane l owns row r = p·LANES + l. The lane is active only if r < N. An inactive lane holds ram_rd_en=0 and row/col=0 for the whole pass.
- RUN:
  - Each cycle, every active lane drives ram_rd_en=1, ram_row=r, ram_col=c.
  - c increments each cycle. After c = N−1 is issued, go to DRAIN.
- Accumulate: one cycle after each read, acc_l += ram_data_l · x[c_delayed]. The product is 2·DATA_W wide and zero-extended to ACC_W.
- DRAIN: absorb the final read, then write acc_l to result slot r for each active lane and clear the accumulators.
  - If p < P−1: p++, c=0, go to RUN.
  - Otherwise go to DONE.
- DONE: op_done=1 for one cycle, then go to IDLE.
- result holds its value until the next accepted start. Slots ≥ N read 0 after any operation.
- start while busy is ignored; it is neither queued nor errored.
- Overflow without MXV_SAT_EN: the sum wraps modulo 2^ACC_W.

## Timing
- Reset (rst=0, immediate): state IDLE; busy, op_done, size_err, ram_rd_en, ram_row, ram_col = 0; result = 0; accumulators cleared.
- Reset mid-operation aborts with no op_done.
- Let start be accepted at edge E0:
  - busy=1 and the first reads occur in the cycle after E0.
  - op_done is high in the cycle after edge E0 + P·(N+1).
  - busy falls together with op_done.
- Each pass takes N issue cycles plus 1 drain cycle, with no bubble between passes.
- size_err is high in the cycle after the offending start edge.
- result updates at the DRAIN edge of each pass. All slots are final when op_done is high.

## Configuration
- MXV_SAT_EN defined: each accumulate saturates at 2^ACC_W − 1 and stays there for the rest of that row.
- MXV_SAT_EN undefined: plain modulo-2^ACC_W addition.

## Test plan
- Identity, N=4, x=(1,2,3,4): result = 1,2,3,4, slots 4..7 = 0; op_done exactly 5 cycles after the start edge; reads cover col 0..3 on lanes 0..3.
- N=5, LANES=4, all A and x = 255: two passes; in pass 2 only lane 0 is active (row 4); result[0..4] = 325125, slots 5..7 = 0; op_done 12 cycles after start.
- mat_size=0 and mat_size=9: size_err pulses 1 cycle, busy stays 0, previous result is retained.
- start re-pulsed at cycle 2 of a run is ignored (single op_done). rst low at cycle 3 gives all outputs 0 at once and no op_done; a new start then completes normally.
- ACC_W=16 override, N=2, all 255: result = 65535 with MXV_SAT_EN, and 64514 (130050 mod 65536) without it.
- N=1, A=7, x=9: result[0] = 63; op_done 2 cycles after start; back-to-back start in the cycle after op_done is accepted.
